iq_sample_fifo: RTL and testbench

Show-ahead (first-word-fall-through) sample buffer between the Deserializer and the Packetizer. It absorbs 32-bit IQ words written at the ADC-side rate and presents them on the rd_en/rd_data/rd_dr interface the Packetizer consumes. The Packetizer samples rd_data in the same cycle it pulses rd_en. The block also flags when a full UDP payload of samples is buffered, and counts overflow and underflow events for debug.

---
 rtl/iq_sample_fifo.sv | 125 ++++++++++++
 tb/tb_iq_sample_fifo.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/iq_sample_fifo.sv
// Show-ahead IQ sample buffer: the head word is held in a register so it is
// valid on rd_data whenever rd_dr is high, with no comb path from the strobes.
module iq_sample_fifo #(
    parameter int ADDR_W      = 10,
    parameter int PKT_SAMPLES = 366
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [31:0]       wr_data,
    output logic              wr_full,
    input  logic              rd_en,
    output logic [31:0]       rd_data,
    output logic              rd_dr,
    output logic [ADDR_W:0]   level,
    output logic              pkt_avail,
    output logic [15:0]       overflow_cnt,
    output logic              underflow,
    input  logic              clr_stats
);

    localparam int              DEPTH    = 1 << ADDR_W;
    localparam logic [ADDR_W:0] FULL_LVL = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] PKT_LVL  = (ADDR_W + 1)'(PKT_SAMPLES);
    localparam logic [ADDR_W-1:0] PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [31:0]       r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_level;
    logic              r_rd_dr;
    logic              r_wr_full;
    logic              r_pkt_avail;
    logic [31:0]       r_rd_data;
    logic [15:0]       r_overflow_cnt;
    logic              r_underflow;

    logic              w_pop;
    logic              w_wr_acc;
    logic              w_overflow;
    logic              w_underflow;
    logic [ADDR_W:0]   w_level_nxt;
    logic [ADDR_W-1:0] w_head_addr;
    logic              w_head_bypass;

    // A full FIFO still accepts a write when the head is popped in the same cycle.
    assign w_pop       = rd_en & r_rd_dr;
    assign w_wr_acc    = wr_en & (~r_wr_full | w_pop);
    assign w_overflow  = wr_en & r_wr_full & ~w_pop;
    assign w_underflow = rd_en & ~r_rd_dr;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_level_nxt = r_level;
        case ({w_wr_acc, w_pop})
            2'b10:   w_level_nxt = r_level + 1'b1;
            2'b01:   w_level_nxt = r_level - 1'b1;
            default: w_level_nxt = r_level;
        endcase
    end

    // The next head is the word being written right now when the FIFO was empty,
    // or held one word that is popped in this cycle.
    assign w_head_addr   = w_pop ? (r_rd_ptr + PTR_ONE) : r_rd_ptr;
    assign w_head_bypass = w_wr_acc & (w_head_addr == r_wr_ptr);

    // NOTE: storage has no reset; pointers and level alone define what is valid.
    always_ff @(posedge clk) begin
        if (!rst && w_wr_acc) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
            r_rd_dr     <= 1'b0;
            r_wr_full   <= 1'b0;
            r_pkt_avail <= 1'b0;
            r_rd_data   <= '0;
        end else begin
            if (w_wr_acc) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop)    r_rd_ptr <= r_rd_ptr + PTR_ONE;
            r_level     <= w_level_nxt;
            r_rd_dr     <= (w_level_nxt != '0);
            r_wr_full   <= (w_level_nxt == FULL_LVL);
            r_pkt_avail <= (w_level_nxt >= PKT_LVL);
            if (w_level_nxt != '0) begin
                r_rd_data <= w_head_bypass ? wr_data : r_mem[w_head_addr];
            end
        end
    end

    // Debug statistics: an event in the same cycle as clr_stats takes precedence.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow_cnt <= '0;
            r_underflow    <= 1'b0;
        end else begin
            if (clr_stats) begin
                r_overflow_cnt <= w_overflow ? 16'd1 : 16'd0;
            end else if (w_overflow && (r_overflow_cnt != 16'hFFFF)) begin
                r_overflow_cnt <= r_overflow_cnt + 16'd1;
            end

            if (w_underflow) begin
                r_underflow <= 1'b1;
            end else if (clr_stats) begin
                r_underflow <= 1'b0;
            end
        end
    end

    assign wr_full      = r_wr_full;
    assign rd_data      = r_rd_data;
    assign rd_dr        = r_rd_dr;
    assign level        = r_level;
    assign pkt_avail    = r_pkt_avail;
    assign overflow_cnt = r_overflow_cnt;
    assign underflow    = r_underflow;

endmodule

// File: tb/tb_iq_sample_fifo.sv
// Directed bench for iq_sample_fifo: a vector table for single-cycle behaviour
// plus sequences for packet threshold, full/overflow, random streaming and reset.
module tb_iq_sample_fifo;

    localparam int ADDR_W = 10;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int PKT    = 366;

    logic              clk = 1'b0;
    logic              rst;
    logic              wr_en;
    logic [31:0]       wr_data;
    logic              wr_full;
    logic              rd_en;
    logic [31:0]       rd_data;
    logic              rd_dr;
    logic [ADDR_W:0]   level;
    logic              pkt_avail;
    logic [15:0]       overflow_cnt;
    logic              underflow;
    logic              clr_stats;

    int n_checks = 0;
    int n_fail   = 0;

    iq_sample_fifo #(.ADDR_W(ADDR_W), .PKT_SAMPLES(PKT)) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .wr_full      (wr_full),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .rd_dr        (rd_dr),
        .level        (level),
        .pkt_avail    (pkt_avail),
        .overflow_cnt (overflow_cnt),
        .underflow    (underflow),
        .clr_stats    (clr_stats)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic        rd;
        logic        clr;
        logic [31:0] data;
        logic        e_dr;
        logic [31:0] e_data;
        int          e_level;
        logic        e_uf;
    } vec_t;

    vec_t vecs [13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Inputs are driven and outputs sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en     = 1'b0;
        rd_en     = 1'b0;
        clr_stats = 1'b0;
        wr_data   = '0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic write_word(input logic [31:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    initial begin
        logic [31:0] q [$];
        logic [31:0] exp_w;
        int          n_wr;
        int          n_rd;
        logic        w;
        logic        r;
        logic        pop;

        vecs[0]  = '{1'b1, 1'b0, 1'b0, 32'h0001_0002, 1'b1, 32'h0001_0002, 1, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000, 0, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 32'h0000_000A, 1'b1, 32'h0000_000A, 1, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 32'h0000_000B, 1'b1, 32'h0000_000A, 2, 1'b0};
        vecs[4]  = '{1'b1, 1'b1, 1'b0, 32'h0000_000C, 1'b1, 32'h0000_000B, 2, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 32'h0000_000C, 1, 1'b0};
        vecs[6]  = '{1'b1, 1'b1, 1'b0, 32'h0000_000D, 1'b1, 32'h0000_000D, 1, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000, 0, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000, 0, 1'b1};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000, 0, 1'b1};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 32'h0000_0000, 1'b0, 32'h0000_0000, 0, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 1'b1, 32'h0000_0000, 1'b0, 32'h0000_0000, 0, 1'b1};
        vecs[12] = '{1'b0, 0, 1'b1, 32'h0000_0000, 1'b0, 32'h0000_0000, 0, 1'b0};

        // Reset state
        idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("rst_level",     32'(level),        32'd0);
        check("rst_rd_dr",     32'(rd_dr),        32'd0);
        check("rst_rd_data",   rd_data,           32'd0);
        check("rst_wr_full",   32'(wr_full),      32'd0);
        check("rst_pkt_avail", 32'(pkt_avail),    32'd0);
        check("rst_ovf_cnt",   32'(overflow_cnt), 32'd0);
        check("rst_underflow", 32'(underflow),    32'd0);

        // Single-cycle vector table
        for (int i = 0; i < 13; i++) begin
            wr_en     = vecs[i].wr;
            rd_en     = vecs[i].rd;
            clr_stats = vecs[i].clr;
            wr_data   = vecs[i].data;
            tick();
            check($sformatf("vec%0d_rd_dr", i), 32'(rd_dr), 32'(vecs[i].e_dr));
            if (vecs[i].e_dr) check($sformatf("vec%0d_rd_data", i), rd_data, vecs[i].e_data);
            check($sformatf("vec%0d_level", i), 32'(level), 32'(vecs[i].e_level));
            check($sformatf("vec%0d_underflow", i), 32'(underflow), 32'(vecs[i].e_uf));
        end
        idle();

        // Packet threshold and full-rate drain
        do_reset();
        for (int i = 0; i < PKT; i++) begin
            write_word(32'(i));
            check("pkt_level", 32'(level), 32'(i + 1));
            check("pkt_avail_fill", 32'(pkt_avail), (i + 1 >= PKT) ? 32'd1 : 32'd0);
        end
        rd_en = 1'b1;
        for (int i = 0; i < PKT; i++) begin
            check("pkt_drain_dr", 32'(rd_dr), 32'd1);
            check("pkt_drain_data", rd_data, 32'(i));
            tick();
            check("pkt_avail_drain", 32'(pkt_avail), 32'd0);
        end
        rd_en = 1'b0;
        check("pkt_empty_dr", 32'(rd_dr), 32'd0);
        check("pkt_empty_level", 32'(level), 32'd0);

        // Fill to DEPTH, overflow, simultaneous write and pop when full
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            write_word(32'h1000_0000 + 32'(i));
        end
        check("full_wr_full", 32'(wr_full), 32'd1);
        check("full_level", 32'(level), 32'(DEPTH));
        check("full_pkt_avail", 32'(pkt_avail), 32'd1);
        for (int k = 0; k < 3; k++) begin
            write_word(32'hBAD0_0000 + 32'(k));
        end
        check("ovf_cnt3", 32'(overflow_cnt), 32'd3);
        check("ovf_level", 32'(level), 32'(DEPTH));
        check("ovf_head", rd_data, 32'h1000_0000);
        wr_en   = 1'b1;
        rd_en   = 1'b1;
        wr_data = 32'h2000_0000;
        tick();
        idle();
        check("fullrw_level", 32'(level), 32'(DEPTH));
        check("fullrw_ovf", 32'(overflow_cnt), 32'd3);
        check("fullrw_wr_full", 32'(wr_full), 32'd1);
        check("fullrw_head", rd_data, 32'h1000_0001);
        wr_en     = 1'b1;
        clr_stats = 1'b1;
        wr_data   = 32'hBAD0_00FF;
        tick();
        idle();
        check("clr_ovf_wins", 32'(overflow_cnt), 32'd1);
        clr_stats = 1'b1;
        tick();
        idle();
        check("clr_ovf", 32'(overflow_cnt), 32'd0);
        rd_en = 1'b1;
        for (int j = 0; j < DEPTH; j++) begin
            exp_w = (j < DEPTH - 1) ? (32'h1000_0001 + 32'(j)) : 32'h2000_0000;
            check("full_drain_data", rd_data, exp_w);
            tick();
        end
        idle();
        check("full_drain_dr", 32'(rd_dr), 32'd0);
        check("full_drain_wr_full", 32'(wr_full), 32'd0);
        check("full_drain_uf", 32'(underflow), 32'd0);

        // Random stream across pointer wrap against a queue scoreboard
        do_reset();
        n_wr = 0;
        n_rd = 0;
        for (int cyc = 0; cyc < 20000 && n_rd < 3000; cyc++) begin
            w   = (n_wr < 3000) && ($urandom_range(0, 1) == 1) && (q.size() < DEPTH);
            r   = ($urandom_range(0, 1) == 1);
            pop = r && (q.size() > 0);
            wr_en   = w;
            rd_en   = r;
            wr_data = 32'hA500_0000 + 32'(n_wr);
            tick();
            if (pop) begin
                void'(q.pop_front());
                n_rd++;
            end
            if (w) begin
                q.push_back(32'hA500_0000 + 32'(n_wr));
                n_wr++;
            end
            check("stream_level", 32'(level), 32'(q.size()));
            check("stream_rd_dr", 32'(rd_dr), (q.size() != 0) ? 32'd1 : 32'd0);
            if (q.size() != 0) check("stream_rd_data", rd_data, q[0]);
        end
        idle();
        check("stream_done", 32'(n_rd), 32'd3000);

        // Reset mid-stream discards buffered words
        do_reset();
        for (int i = 0; i < 500; i++) begin
            write_word(32'h3000_0000 + 32'(i));
        end
        check("mid_level_pre", 32'(level), 32'd500);
        do_reset();
        check("mid_rst_level", 32'(level), 32'd0);
        check("mid_rst_rd_dr", 32'(rd_dr), 32'd0);
        write_word(32'hDEAD_BEEF);
        check("mid_rd_dr", 32'(rd_dr), 32'd1);
        check("mid_rd_data", rd_data, 32'hDEAD_BEEF);
        check("mid_level", 32'(level), 32'd1);
        rd_en = 1'b1;
        tick();
        idle();
        check("mid_pop_dr", 32'(rd_dr), 32'd0);
        check("mid_pop_uf", 32'(underflow), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
